// File: rtl/edge_frame_capture.sv
// edge_frame_capture
// Captures one frame of 8-bit edge-magnitude pixels into an internal RAM.
// While capturing, it counts the pixels at or above a programmable threshold.
// It then streams the frame out over a ready/valid byte interface.
// Optional feature macro: CAPTURE_HEADER_EN. When it is defined, the frame is
// preceded by a 4-byte header: 0xA5 followed by edge_count, MSB first.

module edge_frame_capture #(
    parameter int COLS = 509,
    parameter int ROWS = 510
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  threshold,
    input  logic [7:0]  pixel_in,
    input  logic        valid_in,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        frame_done,
    output logic [23:0] edge_count,
    output logic        drop_err
);

    localparam int PIX = COLS * ROWS;
    localparam int AW  = $clog2(PIX);
`ifdef CAPTURE_HEADER_EN
    localparam int HDR = 4;
`else
    localparam int HDR = 0;
`endif
    localparam int TOTAL = PIX + HDR;
    localparam int CW    = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

    state_t        state;
    state_t        state_nxt;

    logic [7:0]    mem [PIX];
    logic [AW-1:0] wr_addr;
    logic [7:0]    thr;

    // iss counts stream positions already fetched into the prefetch stage.
    // tx_cnt counts bytes that have been handed to the consumer.
    logic [CW-1:0] iss;
    logic [CW-1:0] tx_cnt;
    logic [AW-1:0] ram_addr;
    logic          ram_re;
    logic [7:0]    rd_q;
    logic [7:0]    s1_data;
    logic          s1_vld;

    logic          start_ok;
    logic          wr_en;
    logic          wr_last;
    logic          xfer;
    logic          xfer_last;
    logic          out_load;
    logic          iss_en;
    logic          iss_more;

    assign start_ok  = (state == IDLE) && start;
    assign wr_en     = (state == CAPTURE) && valid_in;
    assign wr_last   = wr_en && (wr_addr == AW'(PIX - 1));
    assign xfer      = out_valid && out_ready;
    assign xfer_last = (state == DRAIN) && xfer && (tx_cnt == CW'(TOTAL - 1));
    assign out_load  = !out_valid || out_ready;
    assign iss_en    = (state == DRAIN) && (!s1_vld || out_load);
    assign iss_more  = iss < CW'(TOTAL);
    assign ram_addr  = AW'(iss - CW'(HDR));

    // Frame store: capture-side write port and a clock-enabled synchronous
    // read port. The read port holds its data while the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= pixel_in;
        if (ram_re)
            rd_q <= mem[ram_addr];
    end

`ifdef CAPTURE_HEADER_EN
    logic       s1_hdr;
    logic [7:0] hdr_q;

    assign ram_re  = iss_en && iss_more && (iss >= CW'(HDR));
    assign s1_data = s1_hdr ? hdr_q : rd_q;

    // Header bytes share the prefetch slot with RAM data. edge_count is
    // frozen during DRAIN, so sampling it here is safe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_hdr <= 1'b0;
            hdr_q  <= 8'h00;
        end else if (iss_en) begin
            s1_hdr <= (iss < CW'(HDR));
            case (iss[1:0])
                2'd0:    hdr_q <= 8'hA5;
                2'd1:    hdr_q <= edge_count[23:16];
                2'd2:    hdr_q <= edge_count[15:8];
                default: hdr_q <= edge_count[7:0];
            endcase
        end
    end
`else
    assign ram_re  = iss_en && iss_more;
    assign s1_data = rd_q;
`endif

    // Control state, the capture write pointer, the threshold, the edge
    // counter and the sticky drop flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wr_addr    <= '0;
            thr        <= 8'h00;
            edge_count <= 24'h0;
            drop_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                wr_addr    <= '0;
                thr        <= threshold;
                edge_count <= 24'h0;
            end else if (wr_en) begin
                wr_addr <= wr_addr + AW'(1);
                if ((pixel_in >= thr) && (edge_count != 24'hFFFFFF))
                    edge_count <= edge_count + 24'd1;
            end
            // A pixel dropped in the same cycle as an accepted start is
            // still reported.
            if (valid_in && (state != CAPTURE))
                drop_err <= 1'b1;
            else if (start_ok)
                drop_err <= 1'b0;
        end
    end

    // Readout pipeline: the prefetch stage (s1) refills whenever the output
    // register can advance, which sustains one byte per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss       <= '0;
            tx_cnt    <= '0;
            s1_vld    <= 1'b0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
        end else if (wr_last) begin
            iss       <= '0;
            tx_cnt    <= '0;
            s1_vld    <= 1'b0;
            out_valid <= 1'b0;
        end else if (state == DRAIN) begin
            if (iss_en) begin
                s1_vld <= iss_more;
                if (iss_more)
                    iss <= iss + CW'(1);
            end
            if (out_load) begin
                out_valid <= s1_vld && !xfer_last;
                if (s1_vld)
                    out_data <= s1_data;
            end
            if (xfer)
                tx_cnt <= tx_cnt + CW'(1);
        end else begin
            out_valid <= 1'b0;
            s1_vld    <= 1'b0;
        end
    end

    // Next-state logic and the state-decoded status outputs.
    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = CAPTURE;
            end
            CAPTURE: begin
                busy = 1'b1;
                if (wr_last)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (xfer_last)
                    state_nxt = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_edge_frame_capture.sv
// Self-checking bench for edge_frame_capture with a 4x3 frame.
// A scoreboard queue holds the bytes expected on the output stream, and a
// negedge monitor pops entries from it as transfers occur.

module tb_edge_frame_capture;

    localparam int PIX = 12;
`ifdef CAPTURE_HEADER_EN
    localparam int HDR = 4;
`else
    localparam int HDR = 0;
`endif
    localparam int TOTAL = PIX + HDR;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  threshold;
    logic [7:0]  pixel_in;
    logic        valid_in;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        frame_done;
    logic [23:0] edge_count;
    logic        drop_err;

    int          checks;
    int          passes;
    int          cyc;
    int          xfer_n;
    int          first_valid_edge;
    int          last_wr_edge;
    int          ready_mode;
    int          rdy_ph;
    int          exp_count;
    logic        stall_prev;
    logic [7:0]  stall_data;
    logic [7:0]  exp_q[$];

    edge_frame_capture #(.COLS(4), .ROWS(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .threshold  (threshold),
        .pixel_in   (pixel_in),
        .valid_in   (valid_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .edge_count (edge_count),
        .drop_err   (drop_err)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter that numbers the rising edges.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Consumer readiness: either always ready or the repeating 1,0,0,1 pattern.
    initial begin
        out_ready = 1'b1;
        rdy_ph    = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) begin
                out_ready = 1'b1;
            end else begin
                out_ready = (rdy_ph == 0) || (rdy_ph == 3);
                rdy_ph    = (rdy_ph + 1) % 4;
            end
        end
    end

    // Output monitor: scoreboard compare on each transfer, stall stability,
    // and the first out_valid edge of a frame.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checkOutput("stall keeps valid", {31'b0, out_valid}, 1);
                checkOutput("stall keeps data", {24'b0, out_data}, {24'b0, stall_data});
            end
            if (out_valid === 1'b1 && first_valid_edge < 0)
                first_valid_edge = cyc;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0)
                    checkOutput("unexpected byte", 32'(exp_q.size()), 1);
                else
                    checkOutput("stream byte", {24'b0, out_data}, {24'b0, exp_q.pop_front()});
                xfer_n++;
            end
            stall_prev = (out_valid === 1'b1) && (out_ready === 1'b0);
            stall_data = out_data;
        end
    end

    // Starts a frame and feeds pixels 0x00,0x10,...,0xB0.
    // valid_in is high for one cycle out of every 'gap' cycles.
    task automatic applyStimulus(input logic [7:0] thr, input int gap);
        int cnt;
        logic [7:0] px;
        cnt = 0;
        for (int i = 0; i < PIX; i++) begin
            px = 8'(i * 16);
            if (px >= thr) cnt++;
        end
`ifdef CAPTURE_HEADER_EN
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(cnt >> 16));
        exp_q.push_back(8'(cnt >> 8));
        exp_q.push_back(8'(cnt));
`endif
        for (int i = 0; i < PIX; i++) exp_q.push_back(8'(i * 16));
        exp_count        = cnt;
        xfer_n           = 0;
        first_valid_edge = -1;
        @(posedge clk);
        #1;
        start     = 1'b1;
        threshold = thr;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busy after start", {31'b0, busy}, 1);
        for (int i = 0; i < PIX; i++) begin
            valid_in     = 1'b1;
            pixel_in     = 8'(i * 16);
            last_wr_edge = cyc + 1;
            @(posedge clk);
            #1;
            valid_in = 1'b0;
            for (int g = 1; g < gap; g++) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Waits, with a bound, for frame_done, then checks the frame outcome.
    task automatic waitFrameDone(input string tag);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            if (frame_done === 1'b1) seen = 1'b1;
        end
        checkOutput({tag, " frame_done seen"}, {31'b0, seen}, 1);
        if (seen) begin
            checkOutput({tag, " out_valid at done"}, {31'b0, out_valid}, 0);
            checkOutput({tag, " busy at done"}, {31'b0, busy}, 0);
            checkOutput({tag, " edge_count"}, {8'b0, edge_count}, exp_count);
            @(negedge clk);
            checkOutput({tag, " frame_done one cycle"}, {31'b0, frame_done}, 0);
            checkOutput({tag, " transfers"}, xfer_n, TOTAL);
            checkOutput({tag, " scoreboard empty"}, 32'(exp_q.size()), 0);
        end
    endtask

    initial begin
        checks     = 0;
        passes     = 0;
        cyc        = 0;
        xfer_n     = 0;
        ready_mode = 0;
        first_valid_edge = -1;
        stall_prev = 1'b0;
        stall_data = 8'h00;
        rst        = 1'b1;
        start      = 1'b0;
        threshold  = 8'h00;
        pixel_in   = 8'h00;
        valid_in   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset out_data", {24'b0, out_data}, 0);
        checkOutput("reset out_valid", {31'b0, out_valid}, 0);
        checkOutput("reset busy", {31'b0, busy}, 0);
        checkOutput("reset frame_done", {31'b0, frame_done}, 0);
        checkOutput("reset edge_count", {8'b0, edge_count}, 0);
        checkOutput("reset drop_err", {31'b0, drop_err}, 0);
        rst = 1'b0;

        $display("[TB] basic frame");
        applyStimulus(8'h80, 1);
        waitFrameDone("basic");

        $display("[TB] backpressure");
        ready_mode = 1;
        applyStimulus(8'h80, 1);
        waitFrameDone("backpressure");
        ready_mode = 0;

        $display("[TB] gapped input");
        applyStimulus(8'h40, 3);
        waitFrameDone("gapped");
        checkOutput("gapped out_valid rise edge", first_valid_edge, last_wr_edge + 2);

        $display("[TB] drop and ignored start");
        @(posedge clk);
        #1;
        valid_in = 1'b1;
        pixel_in = 8'hFF;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        checkOutput("drop_err set in idle", {31'b0, drop_err}, 1);
        checkOutput("idle drop keeps edge_count", {8'b0, edge_count}, exp_count);
        applyStimulus(8'h80, 1);
        checkOutput("drop_err cleared by start", {31'b0, drop_err}, 0);
        repeat (3) @(posedge clk);
        #1;
        start     = 1'b1;
        threshold = 8'h00;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitFrameDone("ignored start");
        repeat (3) @(negedge clk);
        checkOutput("no capture after ignored start", {31'b0, busy}, 0);

        $display("[TB] reset mid drain");
        applyStimulus(8'h80, 1);
        for (int n = 0; n < 200 && xfer_n < 5; n++) @(posedge clk);
        checkOutput("reached 5 transfers", xfer_n, 5);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midreset out_data", {24'b0, out_data}, 0);
        checkOutput("midreset out_valid", {31'b0, out_valid}, 0);
        checkOutput("midreset busy", {31'b0, busy}, 0);
        checkOutput("midreset frame_done", {31'b0, frame_done}, 0);
        checkOutput("midreset edge_count", {8'b0, edge_count}, 0);
        checkOutput("midreset drop_err", {31'b0, drop_err}, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(8'h80, 1);
        waitFrameDone("after reset");

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/edge_frame_capture.md
# edge_frame_capture

Sink and transmitter for the edge-detection pixel stream. It captures one frame of 8-bit edge-magnitude pixels from a valid-qualified stream into internal RAM and counts pixels at or above a programmable threshold. It then transmits the frame over a ready/valid byte interface toward the host link (UART/DMA bridge). It sits directly downstream of the Sobel core and turns its burst output into a flow-controlled readout.

## Interface
- COLS, 509: pixels per captured row
- ROWS, 510: captured rows per frame
- PIX = COLS*ROWS (localparam): frame size; address width AW = $clog2(PIX)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle pulse; arms capture of the next frame
- threshold  in  8  edge threshold; sampled when start is accepted
- pixel_in  in  8  edge pixel
- valid_in  in  1  pixel_in qualifier; no backpressure on this side
- out_data  out  8  transmitted byte
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- busy  out  1  high in CAPTURE or DRAIN
- frame_done  out  1  one-cycle pulse after the last byte transfers
- edge_count  out  24  pixels >= threshold in the current/last frame
- drop_err  out  1  sticky: valid_in seen while not in CAPTURE; cleared by accepted start

## Operation
- RAM: PIX x 8, one write port (capture), one synchronous read port (1-cycle latency).
- FSM states: IDLE, CAPTURE, DRAIN, DONE.
- IDLE: start=1 -> CAPTURE; wr_addr<=0, edge_count<=0, drop_err<=0, thr<=threshold.
- CAPTURE: each valid_in writes mem[wr_addr] and increments wr_addr. If pixel_in >= thr (unsigned), edge_count increments. Write of address PIX-1 -> DRAIN, rd_addr<=0.
- DRAIN: streams mem[0..PIX-1] in address order. The read is prefetched so a new byte can transfer every cycle while out_ready=1. The transfer of byte PIX-1 -> DONE.
- DONE: frame_done=1 for exactly one cycle, then IDLE. edge_count holds until the next accepted start.
- start outside IDLE: ignored, no side effects.
- valid_in outside CAPTURE: pixel discarded, drop_err<=1.
- edge_count saturates at 2^24-1; never wraps.
- Reset mid-operation: FSM returns to IDLE immediately and all counters clear. RAM contents are undefined and never read before being rewritten.

## Timing
- Reset values: out_data=0, out_valid=0, busy=0, frame_done=0, edge_count=0, drop_err=0.
- busy rises on the edge at which start is accepted and falls on the edge entering DONE.
- Capture latency: a pixel accepted at edge N updates edge_count at edge N.
- out_valid first rises at the 2nd rising edge after the edge that writes pixel PIX-1.
- Handshake: a transfer occurs when out_valid && out_ready at a rising edge.
  - While out_valid=1 and out_ready=0, out_data is held stable and out_valid stays high.
  - out_valid never drops between bytes of a frame while RAM data remains; throughput is 1 byte/cycle with out_ready tied high.
- frame_done pulses on the edge after the final transfer; out_valid=0 in the same cycle.

## Configuration
- CAPTURE_HEADER_EN defined:
  - DRAIN first sends a 4-byte header, then pixel data: 0xA5, edge_count[23:16], edge_count[15:8], edge_count[7:0].
  - Header byte 0 appears with the first out_valid, at the same timing as pixel 0 without the header.
  - Total transfers per frame: PIX+4.
- CAPTURE_HEADER_EN undefined: no header; exactly PIX transfers per frame.

## Test plan
All scenarios use COLS=4, ROWS=3 (PIX=12) and the header off unless stated.
- Basic frame: start with threshold=0x80; feed pixels 0x00,0x10,...,0xB0 contiguously; out_ready=1 -> 12 bytes 0x00..0xB0 in order, edge_count=4, one frame_done pulse, busy low afterward.
- Backpressure: same frame; toggle out_ready 1,0,0,1 repeating -> out_data stable during stalls, no byte lost or duplicated, 12 transfers total.
- Gapped input: valid_in high 1 cycle in 3 -> capture completes after the 12th valid pixel; out_valid rises exactly 2 edges after the last write.
- Drop/ignored start: pulse valid_in in IDLE -> drop_err=1; pulse start during DRAIN -> ignored, frame unchanged; next accepted start clears drop_err.
- Reset mid-DRAIN: assert rst after 5 transfers -> all outputs at reset values immediately; a new start and frame then transmit correctly.
- Header build (CAPTURE_HEADER_EN): basic frame -> bytes 0xA5, 0x00, 0x00, 0x04, then 0x00..0xB0; 16 transfers total.
